rmst_to_fifo_tile_2d: RTL
=========================

Name: rmst_to_fifo_tile_2d

Overview:
Parametrised successor of the single-run output-feature-map tile loader. It fetches a 2-D tile (cfg_row_num rows of cfg_row_len words, rows cfg_row_stride bytes apart) through the Avalon read master, unpacks each XDW beat into DW words, and pushes them in order into a downstream load FIFO. Flow control is credit-based against downstream capacity and stalls on almost-full. It sits between the read master and the compute-side load FIFO.

Parameters:
CW, 16, width of length/count fields
DW, 32, output word width
XAW, 32, read-master byte address width
XDW, 128, read-master beat width; must be a multiple of DW
WCNT, XDW/DW, words per beat (>=2)
BLEN, 8, maximum burst length in words; multiple of WCNT
FIFO_CAP, 64, words the path may hold (read-master FIFO plus in-flight); must be >= BLEN

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cfg_base_addr  in  XAW  byte address of row 0
cfg_row_len  in  CW  words per row
cfg_row_num  in  CW  number of rows
cfg_row_stride  in  XAW  byte distance between row starts
load_start  in  1  one-cycle start pulse; cfg_* sampled on this cycle
load_busy  out  1  transfer in progress
load_done  out  1  one-cycle pulse after the last word is pushed
cfg_err  out  1  sticky config error; cleared by the next accepted start
rmst_fixed_location  out  1  constant 0
rmst_read_base  out  XAW  burst byte address
rmst_read_length  out  CW  burst length in bytes
rmst_go  out  1  one-cycle burst request
rmst_done  in  1  read master idle
rmst_user_read_buffer  out  1  pop one beat from the show-ahead read-master FIFO
rmst_user_buffer_data  in  XDW  head beat
rmst_user_data_available  in  1  read-master FIFO not empty
out_data  out  DW  word to the load FIFO
out_push  out  1  write strobe to the load FIFO
out_almost_full  in  1  load FIFO almost full

Behaviour:
- Reset (rst=0, asynchronous): every output and register is 0, FSM goes to IDLE. A reset in the middle of a transfer abandons it and does not pulse load_done. Re-synchronising the read master is the system's responsibility.
- Start validation: load_start in IDLE is accepted only if cfg_row_len != 0, cfg_row_num != 0 and cfg_row_len % WCNT == 0.
  - If the check fails: set cfg_err, stay IDLE, do not pulse load_done.
  - load_start while load_busy=1 is ignored.
- The issue FSM runs independently of the unpack path.
- IDLE: on an accepted start, latch cfg_*, set row_addr=base and rem=row_len, clear cfg_err, load_busy<=1, go to ISSUE.
- ISSUE: define burst = min(BLEN, rem).
  - rmst_go=1 (combinational, one cycle) only when all hold: rmst_done=1, outstanding+burst <= FIFO_CAP, and not the cycle directly after a go.
  - rmst_read_base = current address. rmst_read_length = burst*DW/8.
  - On go: address += burst*DW/8, rem -= burst, outstanding += burst.
  - When rem reaches 0 and more rows remain: row_addr += cfg_row_stride, address = row_addr, rem = row_len.
  - After the last burst of the last row, go to WAIT_DRAIN.
- WAIT_DRAIN: when pushed_words == row_len*row_num (CW-bit product, truncated), pulse load_done for one cycle, load_busy<=0, go to IDLE.
- Credits: outstanding decrements by 1 on every out_push. A go and a push in the same cycle give outstanding += burst-1.
- Unpack:
  - The beat register holds valid=0/1 and a word index 0..WCNT-1.
  - rmst_user_read_buffer = rmst_user_data_available && (!valid || (index==WCNT-1 && !out_almost_full)). The beat is captured on that same edge.
  - Each cycle with valid && !out_almost_full emits word[index] (low word first), then index increments.
  - After word WCNT-1 the register reloads the next beat seamlessly if one is available; otherwise valid drops.
- Output timing:
  - out_data and out_push are registered, one cycle after the word is selected.
  - Steady throughput is one word per cycle.
  - out_almost_full stalls emission on the same cycle. The load FIFO must absorb 1 in-flight word.
- Beat order equals request order. Row boundaries need no special handling because row_len is a multiple of WCNT.
- Counters: outstanding, pushed_words and rem are CW bits and do not wrap for legal configs (row_len*row_num < 2^CW).

Test Plan:
- Single row, WCNT=4, BLEN=8: base=0x1000, len=8, rows=1. Expect one go with base 0x1000, length 32; 8 pushes of words w0..w7, low word first; load_done 1 cycle after the last push; 8 consecutive push cycles.
- Tail burst and stride: len=12, rows=2, stride=0x400. Expect gos at (0x1000,32), (0x1020,16), (0x1400,32), (0x1420,16); 24 pushes in order.
- Credit limit: FIFO_CAP=16, BLEN=8, len=32, out_almost_full held 1. Expect exactly 2 gos and then no more. Release almost-full: remaining gos issue as pushes return credits; all 32 words are delivered.
- Backpressure: toggle out_almost_full every 3 cycles. Expect no word lost or duplicated and no push while almost-full was high on the selecting cycle.
- Config error: len=6 with WCNT=4, or rows=0. Expect cfg_err=1, no go, load_busy stays 0. A following valid start clears cfg_err.
- Reset mid-transfer: assert rst=0 after 3 pushes. Expect all outputs 0 immediately (asynchronous), no load_done, and a following start runs cleanly.

Source files
------------

// File: rtl/rmst_to_fifo_tile_2d.sv
// rmst_to_fifo_tile_2d
//   Fetches a 2-D tile through an Avalon-style read master and streams it word
//   by word into a downstream load FIFO. The tile is cfg_row_num rows of
//   cfg_row_len words, with rows cfg_row_stride bytes apart. Bursts are issued
//   only while the downstream path has room for the whole burst (credit based).
//   Each XDW beat is split into WCNT words, lowest word first.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cfg_*_i                       tile geometry, sampled with load_start_i
//   load_start_i                  one-cycle start request
//   load_busy_o / load_done_o     transfer in progress / one-cycle completion
//   cfg_err_o                     sticky geometry error, cleared by a good start
//   rmst_*_o / rmst_*_i           read-master command and show-ahead beat FIFO
//   out_data_o, out_push_o        registered word and write strobe to load FIFO
//   out_almost_full_i             load FIFO almost full, stalls word emission
//
// Issue FSM
//   state      | meaning
//   IDLE       | waiting for an accepted start
//   ISSUE      | issuing bursts row by row as credits and the read master allow
//   WAIT_DRAIN | all bursts issued, waiting for the last word to be pushed

module rmst_to_fifo_tile_2d #(
  parameter int unsigned CW       = 16,
  parameter int unsigned DW       = 32,
  parameter int unsigned XAW      = 32,
  parameter int unsigned XDW      = 128,
  parameter int unsigned WCNT     = XDW / DW,
  parameter int unsigned BLEN     = 8,
  parameter int unsigned FIFO_CAP = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XAW-1:0]  cfg_base_addr_i,
  input  logic [CW-1:0]   cfg_row_len_i,
  input  logic [CW-1:0]   cfg_row_num_i,
  input  logic [XAW-1:0]  cfg_row_stride_i,
  input  logic            load_start_i,
  output logic            load_busy_o,
  output logic            load_done_o,
  output logic            cfg_err_o,
  output logic            rmst_fixed_location_o,
  output logic [XAW-1:0]  rmst_read_base_o,
  output logic [CW-1:0]   rmst_read_length_o,
  output logic            rmst_go_o,
  input  logic            rmst_done_i,
  output logic            rmst_user_read_buffer_o,
  input  logic [XDW-1:0]  rmst_user_buffer_data_i,
  input  logic            rmst_user_data_available_i,
  output logic [DW-1:0]   out_data_o,
  output logic            out_push_o,
  input  logic            out_almost_full_i
);

  localparam int unsigned IW = (WCNT > 1) ? $clog2(WCNT) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_DRAIN = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  len_q;
  logic [CW-1:0]  rows_left_q;
  logic [CW-1:0]  total_q;
  logic [CW-1:0]  rem_q;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  pushed_q, pushed_d;
  logic [XAW-1:0] stride_q;
  logic [XAW-1:0] row_addr_q;
  logic [XAW-1:0] addr_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic           go_q;

  logic           valid_q;
  logic [IW-1:0]  idx_q;
  logic [XDW-1:0] beat_q;
  logic [DW-1:0]  out_data_q;
  logic           out_push_q;

  logic [CW-1:0]  burst;
  logic [CW-1:0]  burst_bytes;
  logic [CW-1:0]  rem_after;
  logic [CW:0]    credit_need;
  logic [CW-1:0]  total_d;
  logic           start_ok;
  logic           go;
  logic           last_word;
  logic           rd;
  logic           emit;

  // ---------------------------------------------------------------------------
  // Burst sizing and credit check
  // ---------------------------------------------------------------------------
  assign burst       = (rem_q > CW'(BLEN)) ? CW'(BLEN) : rem_q;
  assign burst_bytes = burst * CW'(DW / 8);
  assign rem_after   = rem_q - burst;
  assign credit_need = {1'b0, outstanding_q} + {1'b0, burst};
  assign total_d     = cfg_row_len_i * cfg_row_num_i;

  assign start_ok = (cfg_row_len_i != '0) && (cfg_row_num_i != '0) &&
                    ((cfg_row_len_i % CW'(WCNT)) == '0);

  // The read master needs a cycle to drop rmst_done after a go, so a go is
  // never issued on the cycle directly following another.
  assign go = (state_q == ISSUE) && rmst_done_i && !go_q &&
              (credit_need <= (CW+1)'(FIFO_CAP));

  // A word leaves the path on out_push; a new burst reserves its words up front.
  assign outstanding_d = outstanding_q + (go ? burst : '0) - CW'(out_push_q);
  assign pushed_d      = pushed_q + CW'(out_push_q);

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      len_q         <= '0;
      rows_left_q   <= '0;
      total_q       <= '0;
      rem_q         <= '0;
      outstanding_q <= '0;
      pushed_q      <= '0;
      stride_q      <= '0;
      row_addr_q    <= '0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      go_q          <= 1'b0;
    end else begin
      go_q          <= go;
      done_q        <= 1'b0;
      outstanding_q <= outstanding_d;
      pushed_q      <= pushed_d;

      case (state_q)
        IDLE: begin
          if (load_start_i) begin
            if (start_ok) begin
              len_q       <= cfg_row_len_i;
              rows_left_q <= cfg_row_num_i - CW'(1);
              total_q     <= total_d;
              stride_q    <= cfg_row_stride_i;
              row_addr_q  <= cfg_base_addr_i;
              addr_q      <= cfg_base_addr_i;
              rem_q       <= cfg_row_len_i;
              pushed_q    <= '0;
              err_q       <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (go) begin
            if (rem_after == '0) begin
              if (rows_left_q != '0) begin
                row_addr_q  <= row_addr_q + stride_q;
                addr_q      <= row_addr_q + stride_q;
                rem_q       <= len_q;
                rows_left_q <= rows_left_q - CW'(1);
              end else begin
                rem_q   <= '0;
                state_q <= WAIT_DRAIN;
              end
            end else begin
              addr_q <= addr_q + XAW'(burst_bytes);
              rem_q  <= rem_after;
            end
          end
        end

        WAIT_DRAIN: begin
          // Count the push happening this cycle so done follows the last push
          // by exactly one cycle.
          if (pushed_d == total_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Beat unpack
  // ---------------------------------------------------------------------------
  assign last_word = (idx_q == IW'(WCNT - 1));
  assign emit      = valid_q && !out_almost_full_i;
  // Gated by reset so the pop strobe is quiet while the block is held in reset.
  assign rd        = rst_ni && rmst_user_data_available_i &&
                     (!valid_q || (last_word && !out_almost_full_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      idx_q      <= '0;
      beat_q     <= '0;
      out_data_q <= '0;
      out_push_q <= 1'b0;
    end else begin
      out_push_q <= emit;
      if (emit) begin
        out_data_q <= beat_q[int'(idx_q) * DW +: DW];
      end

      if (rd) begin
        beat_q  <= rmst_user_buffer_data_i;
        valid_q <= 1'b1;
        idx_q   <= '0;
      end else if (emit) begin
        if (last_word) begin
          valid_q <= 1'b0;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign load_busy_o             = busy_q;
  assign load_done_o             = done_q;
  assign cfg_err_o               = err_q;
  assign rmst_fixed_location_o   = 1'b0;
  assign rmst_read_base_o        = addr_q;
  assign rmst_read_length_o      = burst_bytes;
  assign rmst_go_o               = go;
  assign rmst_user_read_buffer_o = rd;
  assign out_data_o              = out_data_q;
  assign out_push_o              = out_push_q;

endmodule
